// File: rtl/ffd_pkg.sv
// rtl/ffd_pkg.sv - mode encodings shared by the universal register, its users and benches
package ffd_pkg;

  typedef logic [2:0] ffd_mode_t;

  localparam ffd_mode_t MODE_HOLD = 3'd0;
  localparam ffd_mode_t MODE_LOAD = 3'd1;
  localparam ffd_mode_t MODE_SHL  = 3'd2;
  localparam ffd_mode_t MODE_SHR  = 3'd3;
  localparam ffd_mode_t MODE_ROL  = 3'd4;
  localparam ffd_mode_t MODE_ROR  = 3'd5;
  localparam ffd_mode_t MODE_TGL  = 3'd6;
  localparam ffd_mode_t MODE_CLR  = 3'd7;

endpackage

// File: rtl/ffd_univ_reg_if.sv
// rtl/ffd_univ_reg_if.sv - operation/data bundle between a user and the universal register
interface ffd_univ_reg_if #(
  parameter int WIDTH = 8
) ();
  import ffd_pkg::*;

  logic             en;
  ffd_mode_t        mode;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             changed;

  modport master (
    output en, mode, d, sin,
    input  q, sout, changed
  );

  modport slave (
    input  en, mode, d, sin,
    output q, sout, changed
  );

endinterface

// File: rtl/ffd_univ_reg_next.sv
// rtl/ffd_univ_reg_next.sv - combinational next-q / next-sout function of the universal register
module ffd_univ_next
  import ffd_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             en,
  input  ffd_mode_t        mode,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             sout,
  output logic [WIDTH-1:0] q_nxt,
  output logic             sout_nxt
);

  logic [WIDTH-1:0] shl_v;
  logic [WIDTH-1:0] shr_v;
  logic [WIDTH-1:0] rol_v;
  logic [WIDTH-1:0] ror_v;

  // A 1-bit register has no interior bits: shifts replace it with sin, rotates keep it.
  generate
    if (WIDTH == 1) begin : g_w1
      assign shl_v = sin;
      assign shr_v = sin;
      assign rol_v = q;
      assign ror_v = q;
    end else begin : g_wn
      assign shl_v = {q[WIDTH-2:0], sin};
      assign shr_v = {sin, q[WIDTH-1:1]};
      assign rol_v = {q[WIDTH-2:0], q[WIDTH-1]};
      assign ror_v = {q[0], q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    q_nxt    = q;
    sout_nxt = sout;
    if (en) begin
      case (mode)
        MODE_HOLD: ;
        MODE_LOAD: q_nxt = d;
        MODE_SHL: begin
          q_nxt    = shl_v;
          sout_nxt = q[WIDTH-1];
        end
        MODE_SHR: begin
          q_nxt    = shr_v;
          sout_nxt = q[0];
        end
        MODE_ROL: begin
          q_nxt    = rol_v;
          sout_nxt = q[WIDTH-1];
        end
        MODE_ROR: begin
          q_nxt    = ror_v;
          sout_nxt = q[0];
        end
        MODE_TGL: q_nxt = q ^ d;
        MODE_CLR: begin
          q_nxt    = RST_VAL;
          sout_nxt = 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ffd_univ_reg.sv
// rtl/ffd_univ_reg.sv - WIDTH-bit universal register (load/shift/rotate/toggle/clear) with change flag
module ffd_univ_reg
  import ffd_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  ffd_univ_reg_if.slave  bus
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             changed_q, changed_d;

  ffd_univ_next #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_next (
    .en       (bus.en),
    .mode     (bus.mode),
    .q        (q_q),
    .d        (bus.d),
    .sin      (bus.sin),
    .sout     (sout_q),
    .q_nxt    (q_d),
    .sout_nxt (sout_d)
  );

  always_comb begin
    changed_d = bus.en && (q_d != q_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q       <= RST_VAL;
      sout_q    <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      sout_q    <= sout_d;
      changed_q <= changed_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.sout    = sout_q;
  assign bus.changed = changed_q;

endmodule
